// File: rtl/if_id_latch.sv
// IF/ID pipeline register: captures fetch outputs, with stall hold, flush bubble and sticky halt lock.
// Optional performance counters (stall_cnt, bubble_cnt) are built when IFID_PERF_EN is defined.
module if_id_latch #(
    parameter int unsigned       WIDTH     = 16,
    parameter logic [WIDTH-1:0]  NOP_INSTR = 16'h0800,
    parameter logic [4:0]        HALT_OPC  = 5'b00000,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] instr_in,
    input  logic [WIDTH-1:0] pc_next_in,
    input  logic [WIDTH-1:0] pc_curr_in,
    input  logic             stall,
    input  logic             flush,
    output logic [WIDTH-1:0] instr_out,
    output logic [WIDTH-1:0] pc_next_out,
    output logic [WIDTH-1:0] pc_curr_out,
    output logic             valid_out,
    output logic             halted_out
`ifdef IFID_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] instr_d, pc_next_d, pc_curr_d;
    logic             valid_d, halted_d;
    logic             is_halt_c;

    assign is_halt_c = (instr_in[WIDTH-1 -: 5] == HALT_OPC);

    // State and pipeline payload registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            instr_out   <= NOP_INSTR;
            pc_next_out <= '0;
            pc_curr_out <= '0;
            valid_out   <= 1'b0;
            halted_out  <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_out   <= instr_d;
            pc_next_out <= pc_next_d;
            pc_curr_out <= pc_curr_d;
            valid_out   <= valid_d;
            halted_out  <= halted_d;
        end
    end

    // Next state: flush beats stall beats halt-detect beats plain capture
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_out;
        pc_next_d = pc_next_out;
        pc_curr_d = pc_curr_out;
        valid_d   = valid_out;
        halted_d  = halted_out;

        if (flush) begin
            state_d   = RUN;
            instr_d   = NOP_INSTR;
            pc_next_d = pc_next_in;
            pc_curr_d = pc_curr_in;
            valid_d   = 1'b0;
            halted_d  = 1'b0;
        end else begin
            case (state_q)
                RUN, HOLD: begin
                    if (stall) begin
                        state_d = HOLD;
                    end else begin
                        instr_d   = instr_in;
                        pc_next_d = pc_next_in;
                        pc_curr_d = pc_curr_in;
                        valid_d   = 1'b1;
                        halted_d  = is_halt_c;
                        state_d   = is_halt_c ? HALT : RUN;
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

`ifdef IFID_PERF_EN
    logic stall_inc_c;

    // A stalled edge counts only when the latch actually holds (not flushed, not halted)
    assign stall_inc_c = stall && !flush && (state_q != HALT);

    // Saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (stall_inc_c && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush && !(&bubble_cnt)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule
